perm_seq_ctrl: RTL and testbench
================================

PERM_SEQ_CTRL -- requirements
Module: perm_seq_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the cycles waited after start or retry before sampling seq_all (legal range 1..255).
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, giving the number of failed permutation checks tolerated before ERR.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one permutation sequence; sampled only in IDLE or ERR.
REQ-006 abort  input  1  synchronous cancel; highest priority after rst.
REQ-007 seq_all  input  64  permutation word from the generator: 16 nibbles, nibble k = seq_all[4k+3:4k].
REQ-008 out_ready  input  1  consumer ready.
REQ-009 out_valid  output  1  element valid.
REQ-010 out_idx  output  4  position k of the current element.
REQ-011 out_data  output  4  nibble k of the captured word.
REQ-012 busy  output  1  high in WAIT, CHECK and ISSUE.
REQ-013 done  output  1  one-cycle pulse after the last element transfers.
REQ-014 err  output  1  high while in ERR.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, CHECK, ISSUE, DONE and ERR.
REQ-016 IDLE with start=1 SHALL go to WAIT, load the settle counter with SETTLE_CYCLES-1 and clear the retry counter.
REQ-017 WAIT SHALL decrement the counter each cycle; in the cycle it reads 0, the FSM SHALL copy seq_all into a 64-bit snapshot register and go to CHECK.
REQ-018 CHECK SHALL last exactly one cycle and compute a 16-bit mask as the OR of one-hot decodes of the 16 snapshot nibbles.
REQ-019 If the mask is 16'hFFFF, CHECK SHALL go to ISSUE with the index set to 0.
REQ-020 Otherwise CHECK SHALL increment the retry count; at a new count equal to MAX_RETRY it SHALL go to ERR, else to WAIT with the counter reloaded.
REQ-021 In ISSUE, out_valid SHALL be 1, out_idx SHALL equal the index and out_data SHALL equal snapshot nibble[index].
REQ-022 out_valid, out_idx and out_data SHALL hold stable until a transfer (out_valid & out_ready).
REQ-023 Each transfer SHALL increment the index; a transfer at index 15 SHALL go to DONE, with no wrap to 0.
REQ-024 Minimum start-to-first-valid latency SHALL be SETTLE_CYCLES+1 cycles; with out_ready held high, 16 elements SHALL issue on 16 consecutive cycles.
REQ-025 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-026 ERR SHALL hold err=1 and busy=0; start in ERR SHALL clear err and retry count and go to WAIT.
REQ-027 abort=1 in any state SHALL go to IDLE on the next edge, and all outputs SHALL return to their reset values; abort beats a simultaneous start or transfer.
REQ-028 Changes to seq_all after capture SHALL NOT affect issued data; start outside IDLE or ERR SHALL be ignored.
REQ-029 Outside ISSUE, out_valid SHALL be 0, and out_idx and out_data SHALL be 0.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and clear the snapshot, counters, index, out_valid, out_idx, out_data, busy, done and err, including mid-ISSUE.
REQ-031 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-032 With macro PERM_SEQ_CHECK_EN defined, CHECK SHALL behave as in REQ-018 to REQ-020.
REQ-033 Without PERM_SEQ_CHECK_EN, CHECK SHALL always go to ISSUE, the mask and retry logic SHALL be absent, and err SHALL be tied to 0.

Verification
REQ-034 Start with seq_all=64'hFEDCBA9876543210 and out_ready=1 -> out_valid rises 5 cycles after start; out_data sequence 0..F with out_idx 0..15; done pulses once; busy falls.
REQ-035 Same word with out_ready toggling 1,0,1,0 -> each element is held while out_ready=0; 16 transfers total, no duplicates or skips.
REQ-036 With check enabled, seq_all=64'h0 held -> three CHECK failures, then err=1 and busy=0; start with a valid word then completes normally.
REQ-037 Word invalid at first sample and valid (64'h0123456789ABCDEF) at second sample -> one retry; out_data sequence F..0.
REQ-038 rst pulsed at out_idx=7 and abort at out_idx=3 -> out_valid=0 immediately (rst) or next edge (abort); state IDLE; no done pulse.

Source files
------------

// File: rtl/perm_seq_ctrl.sv
// rtl/perm_seq_ctrl.sv - settle/capture/check/issue sequencer for a 16-nibble permutation word
// Optional macro PERM_SEQ_CHECK_EN enables the permutation check and retry/ERR path.
module perm_seq_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] seq_all,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic [3:0]  out_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || MAX_RETRY < 1) begin : g_param_check
    $error("perm_seq_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CHECK, S_ISSUE, S_DONE, S_ERR} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] snap_q, snap_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_idx_q, out_idx_d;
  logic [3:0]  out_data_q, out_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

`ifdef PERM_SEQ_CHECK_EN
  logic [7:0]  retry_q, retry_d;
  logic        err_q, err_d;
  logic [15:0] mask;

  always_comb begin
    mask = '0;
    for (int k = 0; k < 16; k++) mask[snap_q[4*k +: 4]] = 1'b1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;
    out_valid_d = 1'b0;
    out_idx_d   = 4'd0;
    out_data_d  = 4'd0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef PERM_SEQ_CHECK_EN
    retry_d     = retry_q;
    err_d       = 1'b0;
`endif
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      snap_d  = 64'd0;
`ifdef PERM_SEQ_CHECK_EN
      retry_d = 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_WAIT;
            cnt_d   = SETTLE_LOAD;
            busy_d  = 1'b1;
`ifdef PERM_SEQ_CHECK_EN
            retry_d = 8'd0;
`endif
          end
        end
        S_WAIT: begin
          busy_d = 1'b1;
          if (cnt_q == 8'd0) begin
            snap_d  = seq_all;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_CHECK: begin
          busy_d = 1'b1;
`ifdef PERM_SEQ_CHECK_EN
          if (mask == 16'hFFFF) begin
            state_d     = S_ISSUE;
            out_valid_d = 1'b1;
            out_data_d  = snap_q[3:0];
          end else begin
            retry_d = retry_q + 8'd1;
            if (retry_d == 8'(MAX_RETRY)) begin
              state_d = S_ERR;
              busy_d  = 1'b0;
              err_d   = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = SETTLE_LOAD;
            end
          end
`else
          state_d     = S_ISSUE;
          out_valid_d = 1'b1;
          out_data_d  = snap_q[3:0];
`endif
        end
        S_ISSUE: begin
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          out_idx_d   = out_idx_q;
          out_data_d  = out_data_q;
          if (out_ready) begin
            if (out_idx_q == 4'd15) begin
              state_d     = S_DONE;
              done_d      = 1'b1;
              busy_d      = 1'b0;
              out_valid_d = 1'b0;
              out_idx_d   = 4'd0;
              out_data_d  = 4'd0;
            end else begin
              out_idx_d  = out_idx_q + 4'd1;
              out_data_d = snap_q[{out_idx_d, 2'b00} +: 4];
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        S_ERR: begin
`ifdef PERM_SEQ_CHECK_EN
          err_d = 1'b1;
`endif
          if (start) begin
            state_d = S_WAIT;
            cnt_d   = SETTLE_LOAD;
            busy_d  = 1'b1;
`ifdef PERM_SEQ_CHECK_EN
            err_d   = 1'b0;
            retry_d = 8'd0;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      snap_q      <= 64'd0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 4'd0;
      out_data_q  <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef PERM_SEQ_CHECK_EN
      retry_q     <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef PERM_SEQ_CHECK_EN
      retry_q     <= retry_d;
      err_q       <= err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef PERM_SEQ_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_perm_seq_ctrl.sv
// tb/tb_perm_seq_ctrl.sv - self-checking bench for perm_seq_ctrl (honours PERM_SEQ_CHECK_EN)
module tb_perm_seq_ctrl;
`ifdef PERM_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam int SETTLE  = 4;
  localparam int RETRIES = 3;
  localparam logic [63:0] W_UP   = 64'hFEDCBA9876543210;
  localparam logic [63:0] W_DOWN = 64'h0123456789ABCDEF;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [63:0] seq_all = 64'd0;
  logic        out_valid, busy, done, err;
  logic [3:0]  out_idx, out_data;

  perm_seq_ctrl #(.SETTLE_CYCLES(SETTLE), .MAX_RETRY(RETRIES)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_all(seq_all),
    .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, done_seen = 0;
  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // A word is a permutation when every value 0..15 appears somewhere in it.
  function automatic bit is_perm(input logic [63:0] w);
    for (int v = 0; v < 16; v++) begin
      bit found = 1'b0;
      for (int k = 0; k < 16; k++) if (w[4*k +: 4] == 4'(v)) found = 1'b1;
      if (!found) return 1'b0;
    end
    return 1'b1;
  endfunction

  typedef struct {
    string       nm;
    logic [63:0] wa, wb;
    int          swap_lat, mode;
    logic [63:0] ew;
    int          elat;
  } vec_t;
  vec_t vt[4];

  task automatic run_txn(input string nm, input logic [63:0] wa, input logic [63:0] wb,
                         input int swap_lat, input int mode, input logic [63:0] ew, input int elat);
    int lat, k, cyc, d0;
    logic rdy;
    d0 = done_seen;
    @(negedge clk); seq_all = wa; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (lat == swap_lat) seq_all = wb;
      @(negedge clk); lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_err_low"}, 64'(err), 64'd0);
    k = 0; cyc = 0;
    while (k < 16 && cyc < 400) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (mode == 2) begin
        seq_all = {$urandom, $urandom};
        start = 1'($urandom_range(0, 1));
      end
      chk({nm, "_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_idx"}, 64'(out_idx), 64'(k));
      chk({nm, "_data"}, 64'(out_data), 64'(ew[4*k +: 4]));
      @(negedge clk); cyc++;
      if (rdy) k++;
    end
    start = 1'b0; out_ready = 1'b0;
    if (mode == 0) chk({nm, "_consecutive"}, 64'(cyc), 64'd16);
    chk({nm, "_done_pulse"}, 64'(done), 64'd1);
    chk({nm, "_busy_done"}, 64'(busy), 64'd0);
    chk({nm, "_valid_done"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({nm, "_done_clear"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({nm, "_done_count"}, 64'(done_seen - d0), 64'd1);
  endtask

  task automatic reach_idx(input logic [3:0] target, output bit ok);
    int n;
    n = 0;
    @(negedge clk); seq_all = W_UP; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(out_valid === 1'b1 && out_idx == target) && n < 100) begin
      @(negedge clk); n++;
    end
    ok = (out_valid === 1'b1 && out_idx == target);
  endtask

  initial begin
    int d0, lat;
    bit ok;
    logic [3:0]  p[16];
    logic [3:0]  tmp;
    logic [63:0] w;
    int j;

    vt[0] = '{"up_ready",  W_UP,  64'd0,  -1, 0, W_UP,  SETTLE + 1};
    vt[1] = '{"up_toggle", W_UP,  64'd0,  -1, 1, W_UP,  SETTLE + 1};
    vt[2] = '{"one_retry", 64'd0, W_DOWN, SETTLE, 0,
              (CHECK_EN && !is_perm(64'd0)) ? W_DOWN : 64'd0,
              (CHECK_EN && !is_perm(64'd0)) ? 2 * (SETTLE + 1) : SETTLE + 1};
    vt[3] = '{"down_rand", W_DOWN, 64'd0, -1, 2, W_DOWN, SETTLE + 1};

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_over_start", 64'(busy), 64'd0);

    for (int i = 0; i < 4; i++)
      run_txn(vt[i].nm, vt[i].wa, vt[i].wb, vt[i].swap_lat, vt[i].mode, vt[i].ew, vt[i].elat);

    if (CHECK_EN) begin
      @(negedge clk); seq_all = 64'd0; start = 1'b1;
      @(negedge clk); start = 1'b0; lat = 0;
      while (err !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      chk("err_latency", 64'(lat), 64'(RETRIES * (SETTLE + 1)));
      chk("err_busy", 64'(busy), 64'd0);
      chk("err_no_valid", 64'(out_valid), 64'd0);
      run_txn("from_err", W_UP, 64'd0, -1, 0, W_UP, SETTLE + 1);
    end

    d0 = done_seen;
    reach_idx(4'd3, ok);
    chk("abort_reach", 64'(ok), 64'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; out_ready = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_idx", 64'(out_idx), 64'd0);
    chk("abort_data", 64'(out_data), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);

    d0 = done_seen;
    reach_idx(4'd7, ok);
    chk("rst_reach", 64'(ok), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_idx", 64'(out_idx), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_after_rst", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_done", 64'(done_seen - d0), 64'd0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) p[i] = 4'(i);
      for (int i = 15; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = p[i]; p[i] = p[j]; p[j] = tmp;
      end
      w = 64'd0;
      for (int k = 0; k < 16; k++) w[4*k +: 4] = p[k];
      run_txn("rand", w, 64'd0, -1, 2, w, SETTLE + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
